// File: rtl/voter_ballot_ctrl.sv
// Ballot collector for a 4-station voter: gathers one ballot per station, drives the voter, and
// captures its result. Define VOTER_TIMEOUT_EN to force-close a collection after TIMEOUT_CYCLES.
module voter_ballot_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vote_valid,
  input  logic [1:0] vote_id,
  input  logic       vote_val,
  output logic       vote_ready,
  output logic [3:0] I,
  input  logic [3:1] O,
  output logic [3:1] result,
  output logic       result_valid,
  output logic       busy,
  output logic       dup_err,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StCollect, StApply, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] ballot_d;
  logic       handshake;
  logic       dup;
  logic       expired;
  logic       open_election;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  assign handshake     = vote_valid && vote_ready;
  assign dup           = handshake && mask_q[vote_id];
  assign open_election = (state_q == StIdle) && start;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ballot_d = I;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCollect;
          mask_d   = 4'h0;
          ballot_d = 4'h0;
        end
      end
      StCollect: begin
        if (handshake && !mask_q[vote_id]) begin
          mask_d[vote_id]   = 1'b1;
          ballot_d[vote_id] = vote_val;
        end
        // A full mask closes on the following edge, keeping the 2-cycle result latency.
        if (mask_q == 4'hF || expired) begin
          state_d = StApply;
        end
      end
      StApply: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mask_q       <= 4'h0;
      I            <= 4'h0;
      result       <= 3'b000;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      vote_ready   <= 1'b0;
      dup_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      I            <= ballot_d;
      vote_ready   <= (state_d == StCollect);
      busy         <= (state_d != StIdle);
      result_valid <= (state_d == StDone);
      dup_err      <= dup;
      if (state_q == StApply) begin
        result <= O;
      end
    end
  end

`ifdef VOTER_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;

  assign expired = (state_q == StCollect) && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 8'd0;
      timeout <= 1'b0;
    end else begin
      if (open_election) begin
        cnt_q <= 8'd0;
      end else if (state_q == StCollect) begin
        cnt_q <= cnt_q + 8'd1;
      end
      // A ballot landing in the expiry cycle counts; only a still-incomplete mask is a timeout.
      if (open_election) begin
        timeout <= 1'b0;
      end else if (expired && mask_d != 4'hF) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_voter_ballot_ctrl.sv
// Randomised and directed bench for voter_ballot_ctrl against an election-level reference model.
module tb_voter_ballot_ctrl;

  localparam int unsigned TO = 8;
`ifdef VOTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, vote_valid, vote_val;
  logic [1:0] vote_id;
  logic       vote_ready, result_valid, busy, dup_err, timeout;
  logic [3:0] I;
  logic [3:1] O, result;

  always #5 clk = ~clk;

  function automatic logic [3:1] voter_stub(input logic [3:0] b);
    return b[3:1] ^ {b[0] & ~b[3], 2'b00};
  endfunction

  assign O = voter_stub(I);

  voter_ballot_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote_id(vote_id),
    .vote_val(vote_val), .vote_ready(vote_ready), .I(I), .O(O), .result(result),
    .result_valid(result_valid), .busy(busy), .dup_err(dup_err), .timeout(timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: one election as a set of per-station ballots plus a closing countdown.
  bit         m_open;
  int         m_settle;
  bit         m_ballot[4];
  bit         m_got[4];
  int         m_age;
  bit         m_dup;
  bit         m_timeout;
  logic [3:1] m_result;

  function automatic logic [3:0] m_word();
    logic [3:0] w;
    for (int k = 0; k < 4; k++) w[k] = m_ballot[k];
    return w;
  endfunction

  function automatic bit m_full();
    return m_got[0] && m_got[1] && m_got[2] && m_got[3];
  endfunction

  task automatic model_edge();
    bit was_full;
    if (!rst_n) begin
      m_open = 0; m_settle = 0; m_age = 0; m_dup = 0; m_timeout = 0; m_result = 3'b000;
      for (int k = 0; k < 4; k++) begin m_ballot[k] = 0; m_got[k] = 0; end
      return;
    end
    m_dup = 0;
    if (m_settle == 2) begin
      m_result = voter_stub(m_word());
      m_settle = 1;
    end else if (m_settle == 1) begin
      m_settle = 0;
    end else if (!m_open) begin
      if (start) begin
        m_open = 1; m_age = 0; m_timeout = 0;
        for (int k = 0; k < 4; k++) begin m_ballot[k] = 0; m_got[k] = 0; end
      end
    end else begin
      was_full = m_full();
      if (vote_valid) begin
        if (m_got[vote_id]) m_dup = 1;
        else begin m_got[vote_id] = 1; m_ballot[vote_id] = vote_val; end
      end
      m_age++;
      if (was_full || (TO_EN && m_age >= int'(TO))) begin
        m_open = 0;
        m_settle = 2;
        if (!m_full()) m_timeout = 1;
      end
    end
  endtask

  task automatic cycle(input bit st, input bit vv, input int id, input bit vl, input bit rn);
    logic [1:0] id2;
    id2 = id[1:0];
    start = st; vote_valid = vv; vote_id = id2; vote_val = vl; rst_n = rn;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("ready", 32'(vote_ready), 32'(m_open));
    check("busy", 32'(busy), 32'(m_open || m_settle > 0));
    check("result_valid", 32'(result_valid), 32'(m_settle == 1));
    check("I", 32'(I), 32'(m_word()));
    check("dup_err", 32'(dup_err), 32'(m_dup));
    check("timeout", 32'(timeout), 32'(m_timeout));
    check("result", 32'(result), 32'(m_result));
  endtask

  task automatic idle();                    cycle(0, 0, 0, 0, 1);  endtask
  task automatic go();                      cycle(1, 0, 0, 0, 1);  endtask
  task automatic vote(input int id, input bit v); cycle(0, 1, id, v, 1); endtask
  task automatic reset();                   cycle(0, 0, 0, 0, 0);  endtask

  task automatic run_basic();
    go(); vote(0, 1); vote(1, 1); vote(2, 0); vote(3, 1);
    check("basic_I", 32'(I), 32'h0000000b);
    check("basic_rv_early", 32'(result_valid), 32'd0);
    idle();
    check("basic_rv_apply", 32'(result_valid), 32'd0);
    idle();
    check("basic_rv_pulse", 32'(result_valid), 32'd1);
    check("basic_result", 32'(result), 32'd5);
    idle();
    check("basic_rv_end", 32'(result_valid), 32'd0);
    check("basic_idle", 32'(busy), 32'd0);
  endtask

  int since_done;
  int pulses;

  initial begin
    reset();
    check("reset_I", 32'(I), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    run_basic();

    // Duplicate ballot on station 2
    go(); vote(0, 1); vote(1, 1); vote(2, 0); vote(2, 1);
    check("dup_pulse", 32'(dup_err), 32'd1);
    check("dup_I2", 32'(I[2]), 32'd0);
    vote(3, 1);
    check("dup_clear", 32'(dup_err), 32'd0);
    idle(); idle();
    check("dup_rv", 32'(result_valid), 32'd1);
    check("dup_result", 32'(result), 32'd5);
    idle();

    // Reset mid-election
    go(); vote(0, 1); vote(1, 1); reset();
    check("midrst_I", 32'(I), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle();
      check("midrst_no_rv", 32'(result_valid), 32'd0);
    end
    run_basic();

`ifdef VOTER_TIMEOUT_EN
    go(); vote(0, 1);
    repeat (6) idle();
    check("to_still_open", 32'(vote_ready), 32'd1);
    idle();
    check("to_closed", 32'(vote_ready), 32'd0);
    check("to_flag", 32'(timeout), 32'd1);
    check("to_I", 32'(I), 32'd1);
    idle();
    check("to_rv", 32'(result_valid), 32'd1);
    check("to_result", 32'(result), 32'd4);
    idle();

    go(); vote(0, 1); vote(1, 0); vote(2, 1);
    repeat (4) idle();
    vote(3, 1);
    check("exp_flag", 32'(timeout), 32'd0);
    check("exp_closed", 32'(vote_ready), 32'd0);
    check("exp_I", 32'(I), 32'd13);
    idle();
    check("exp_rv", 32'(result_valid), 32'd1);
    check("exp_result", 32'(result), 32'd6);
    idle();
`else
    go(); vote(0, 1);
    repeat (20) idle();
    check("wait_open", 32'(vote_ready), 32'd1);
    check("wait_no_to", 32'(timeout), 32'd0);
    vote(1, 0); vote(2, 1); vote(3, 1);
    idle(); idle();
    check("wait_rv", 32'(result_valid), 32'd1);
    idle();
`endif

    // start held high: one election per IDLE visit
    since_done = 0;
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      int miss;
      bit vv;
      miss = 0;
      while (miss < 3 && m_got[miss]) miss++;
      vv = m_open && !m_full();
      cycle(1, vv, miss, 1'($urandom_range(0, 1)), 1);
      if (since_done == 1) check("held_idle", 32'(busy), 32'd0);
      if (since_done == 2) check("held_restart", 32'(busy), 32'd1);
      if (result_valid === 1'b1) begin pulses++; since_done = 1; end
      else if (since_done > 0) since_done++;
    end
    check("held_pulses", 32'(pulses), 32'd3);
    repeat (3) idle();

    // vote_valid held in IDLE is ignored
    for (int c = 0; c < 6; c++) begin
      cycle(0, 1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1);
      check("idle_no_dup", 32'(dup_err), 32'd0);
      check("idle_no_ready", 32'(vote_ready), 32'd0);
    end

    for (int c = 0; c < 3000; c++) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 199) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/voter_ballot_ctrl.md
VOTER_BALLOT_CTRL -- requirements
Module: voter_ballot_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of COLLECT cycles before forced close (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1, opens an election; sampled only in IDLE.
REQ-005 SHALL have port vote_valid, input, 1, ballot offered this cycle.
REQ-006 SHALL have port vote_id, input, 2, index of the voting station (0..3).
REQ-007 SHALL have port vote_val, input, 1, ballot value (1 = yes).
REQ-008 SHALL have port vote_ready, output, 1, high only in COLLECT.
REQ-009 SHALL have port I, output, 4, registered ballot word driven to the voter; bit n is station n.
REQ-010 SHALL have port O, input, [3:1], combinational result returned by the voter.
REQ-011 SHALL have port result, output, [3:1], captured voter result.
REQ-012 SHALL have port result_valid, output, 1, one-cycle pulse when result updates.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port dup_err, output, 1, one-cycle pulse on a rejected duplicate ballot.
REQ-015 SHALL have port timeout, output, 1, sticky flag indicating the last election closed by timeout.

Function
REQ-016 SHALL implement the states IDLE, COLLECT, APPLY and DONE in a registered FSM.
REQ-017 In IDLE, start=1 SHALL clear the ballot register, received mask, timeout flag and cycle counter, then enter COLLECT.
REQ-018 A handshake SHALL occur when vote_valid && vote_ready; on handshake with mask[vote_id]=0, SHALL set ballot[vote_id]=vote_val and mask[vote_id]=1.
REQ-019 A handshake with mask[vote_id]=1 SHALL leave the ballot unchanged and pulse dup_err for the following cycle.
REQ-020 When the mask becomes 4'hF, SHALL enter APPLY on the next edge.
REQ-021 I SHALL equal the ballot register at all times, including partial ballots during COLLECT.
REQ-022 APPLY SHALL last exactly one cycle; at its closing edge SHALL register O into result and enter DONE.
REQ-023 DONE SHALL assert result_valid for one cycle, then return to IDLE; result SHALL hold until the next capture.
REQ-024 Latency from the edge accepting the final ballot to result_valid high SHALL be 2 cycles.
REQ-025 start asserted outside IDLE SHALL be ignored; start asserted in the DONE cycle SHALL NOT be seen until IDLE.
REQ-026 vote_valid outside COLLECT SHALL be ignored, with no dup_err.

Reset
REQ-027 With rst_n=0 at an edge, SHALL force state=IDLE, I=0, mask=0, result=0, result_valid=0, busy=0, dup_err=0, timeout=0 and counter=0.
REQ-028 Reset mid-election SHALL discard the partial ballot, and no result_valid SHALL follow.

Configuration
REQ-029 With macro VOTER_TIMEOUT_EN defined, SHALL increment the counter each COLLECT cycle.
REQ-030 With VOTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES with the mask incomplete, SHALL set timeout=1, treat missing ballots as 0, and enter APPLY.
REQ-031 With VOTER_TIMEOUT_EN defined, a ballot accepted in the expiry cycle SHALL be recorded first; if it completes the mask, timeout SHALL stay 0.
REQ-032 Without VOTER_TIMEOUT_EN, no counter SHALL exist, COLLECT SHALL wait indefinitely, and timeout SHALL be tied to 0.

Verification
REQ-033 Bench SHALL cover: reset, start, ballots id0=1, id1=1, id2=0, id3=1 with stub O=3'b101 -> I=4'b1011, result=3'b101, result_valid pulse 2 cycles after the id3 handshake.
REQ-034 Bench SHALL cover: a second ballot on id2 with val=1 after id2=0 -> dup_err pulse, I[2] stays 0, election still completes after id3.
REQ-035 Bench SHALL cover, with VOTER_TIMEOUT_EN and TIMEOUT_CYCLES=8: only id0=1 voted -> APPLY after 8 COLLECT cycles, I=4'b0001, timeout=1.
REQ-036 Bench SHALL cover, with VOTER_TIMEOUT_EN and TIMEOUT_CYCLES=8: the last ballot arrives in the expiry cycle -> timeout=0, ballot complete.
REQ-037 Bench SHALL cover: rst_n=0 after two ballots -> I=0, busy=0, no result_valid; the next election behaves per REQ-033.
REQ-038 Bench SHALL cover: start held high through DONE and vote_valid held in IDLE -> exactly one election per IDLE entry, no dup_err.
